// File: rtl/rotate_amount_finder.sv
// rotate_amount_finder
//   Recovers the rotation amount applied by the datapath rotator. Given the
//   rotated word (data_in), the unrotated reference (ref_in) and the direction
//   the rotator used (lr), it walks the candidate back one step per clock until
//   it matches the reference or every amount has been tried.
//
//   State | Meaning
//   ------+-------------------------------------------------------------
//   IDLE  | waiting for start; results hold their last values
//   SEARCH| busy=1, one candidate evaluated per clock
//   DONE  | done=1 for one cycle, results valid
//
// Ports
//   clk        system clock, rising edge
//   reset      synchronous, active-high
//   start      request a search (sampled only in IDLE)
//   data_in    rotated word
//   ref_in     reference word
//   lr         1 = rotator rotated left, 0 = rotated right
//   busy       high while searching
//   done       one-cycle result strobe
//   found      a matching amount exists
//   amt        smallest matching rotation amount (0 on a miss)
//   recovered  data_in undone by amt (latched data_in on a miss)
//   match_mask (ROT_FIND_MASK_EN only) bit k set when rotation k matches
//
// Optional build macro: ROT_FIND_MASK_EN
//   When defined, every rotation is evaluated (no early exit) and the full
//   match set is reported on match_mask.

module rotate_amount_finder #(
    parameter int DATA_W = 8,
    parameter int AMT_W  = $clog2(DATA_W)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] data_in,
    input  logic [DATA_W-1:0] ref_in,
    input  logic              lr,
    output logic              busy,
    output logic              done,
    output logic              found,
    output logic [AMT_W-1:0]  amt,
    output logic [DATA_W-1:0] recovered
`ifdef ROT_FIND_MASK_EN
    ,
    output logic [DATA_W-1:0] match_mask
`endif
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_SEARCH = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next;

    logic [DATA_W-1:0] r_cand;
    logic [DATA_W-1:0] r_dat;
    logic [DATA_W-1:0] r_ref;
    logic              r_lr;
    logic [AMT_W-1:0]  r_cnt;
    logic              r_found;
    logic [AMT_W-1:0]  r_amt;
    logic [DATA_W-1:0] r_rec;

    logic              w_match;
    logic              w_last;
    logic              w_finish;
    logic [DATA_W-1:0] w_undo;

    assign w_match = (r_cand == r_ref);
    assign w_last  = (r_cnt == AMT_W'(DATA_W - 1));

    // Undo one rotator step: a left rotation is undone by rotating right.
    assign w_undo = r_lr ? {r_cand[0], r_cand[DATA_W-1:1]}
                         : {r_cand[DATA_W-2:0], r_cand[DATA_W-1]};

`ifdef ROT_FIND_MASK_EN
    logic [DATA_W-1:0] r_acc;
    logic              r_hit;
    logic [AMT_W-1:0]  r_hit_amt;
    logic [DATA_W-1:0] r_mask;
    logic [DATA_W-1:0] w_acc_next;
    logic              w_hit_next;
    logic [AMT_W-1:0]  w_hit_amt_next;

    // The first match seen is the smallest amount, since cnt only increases.
    always_comb begin
        w_acc_next        = r_acc;
        w_acc_next[r_cnt] = w_match;
        w_hit_next        = r_hit | w_match;
        w_hit_amt_next    = r_hit ? r_hit_amt : r_cnt;
    end

    assign w_finish   = w_last;
    assign match_mask = r_mask;
`else
    assign w_finish = w_match | w_last;
`endif

    always_ff @(posedge clk) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:   if (start) w_next = S_SEARCH;
            S_SEARCH: if (w_finish) w_next = S_DONE;
            S_DONE:   w_next = S_IDLE;
            default:  w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cand    <= '0;
            r_dat     <= '0;
            r_ref     <= '0;
            r_lr      <= 1'b0;
            r_cnt     <= '0;
            r_found   <= 1'b0;
            r_amt     <= '0;
            r_rec     <= '0;
`ifdef ROT_FIND_MASK_EN
            r_acc     <= '0;
            r_hit     <= 1'b0;
            r_hit_amt <= '0;
            r_mask    <= '0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_cand    <= data_in;
                        r_dat     <= data_in;
                        r_ref     <= ref_in;
                        r_lr      <= lr;
                        r_cnt     <= '0;
`ifdef ROT_FIND_MASK_EN
                        r_acc     <= '0;
                        r_hit     <= 1'b0;
                        r_hit_amt <= '0;
`endif
                    end
                end
                S_SEARCH: begin
`ifdef ROT_FIND_MASK_EN
                    if (w_last) begin
                        r_mask  <= w_acc_next;
                        r_found <= w_hit_next;
                        r_amt   <= w_hit_next ? w_hit_amt_next : '0;
                        // A matching candidate is by definition equal to ref.
                        r_rec   <= w_hit_next ? r_ref : r_dat;
                    end else begin
                        r_acc     <= w_acc_next;
                        r_hit     <= w_hit_next;
                        r_hit_amt <= w_hit_amt_next;
                        r_cand    <= w_undo;
                        r_cnt     <= r_cnt + AMT_W'(1);
                    end
`else
                    if (w_match) begin
                        r_found <= 1'b1;
                        r_amt   <= r_cnt;
                        r_rec   <= r_cand;
                    end else if (w_last) begin
                        r_found <= 1'b0;
                        r_amt   <= '0;
                        r_rec   <= r_dat;
                    end else begin
                        r_cand <= w_undo;
                        r_cnt  <= r_cnt + AMT_W'(1);
                    end
`endif
                end
                default: ;
            endcase
        end
    end

    assign busy      = (r_state == S_SEARCH);
    assign done      = (r_state == S_DONE);
    assign found     = r_found;
    assign amt       = r_amt;
    assign recovered = r_rec;

endmodule

// File: tb/tb_rotate_amount_finder.sv
module tb_rotate_amount_finder;

    localparam int DATA_W = 8;
    localparam int AMT_W  = 3;
`ifdef ROT_FIND_MASK_EN
    localparam bit MASK_MODE = 1'b1;
`else
    localparam bit MASK_MODE = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset;
    logic              start;
    logic [DATA_W-1:0] data_in;
    logic [DATA_W-1:0] ref_in;
    logic              lr;
    logic              busy;
    logic              done;
    logic              found;
    logic [AMT_W-1:0]  amt;
    logic [DATA_W-1:0] recovered;
`ifdef ROT_FIND_MASK_EN
    logic [DATA_W-1:0] match_mask;
`endif

    int n_cmp = 0;
    int n_err = 0;

    rotate_amount_finder #(.DATA_W(DATA_W), .AMT_W(AMT_W)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .data_in   (data_in),
        .ref_in    (ref_in),
        .lr        (lr),
        .busy      (busy),
        .done      (done),
        .found     (found),
        .amt       (amt),
        .recovered (recovered)
`ifdef ROT_FIND_MASK_EN
        ,
        .match_mask(match_mask)
`endif
    );

    always #5 clk = ~clk;

    // Issues a start in cycle 0 and returns the cycle in which done was seen
    // (40 if it never came). Inputs are scrambled after start to show they
    // are not resampled.
    task automatic launch(input logic [7:0] r, input logic [7:0] d,
                          input logic l, output int cyc);
        @(negedge clk);
        ref_in = r; data_in = d; lr = l; start = 1'b1;
        @(negedge clk);
        start = 1'b0; data_in = ~d; ref_in = 8'h00; lr = ~l;
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b0; data_in = '0; ref_in = '0; lr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({busy, done, found, amt, recovered} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_outputs: got busy=%b done=%b found=%b amt=%0d rec=%h want all 0",
                     busy, done, found, amt, recovered);
        end
`ifdef ROT_FIND_MASK_EN
        n_cmp++;
        if (match_mask !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mask: got %h want 00", match_mask);
        end
`endif
    endtask

    task automatic test_vectors();
        // ref, data, lr, done cycle (early-exit build), found, amt, recovered, mask
        logic [7:0] t_ref  [6] = '{8'hB4, 8'h81, 8'h3C, 8'hFF, 8'h00, 8'h55};
        logic [7:0] t_dat  [6] = '{8'hA5, 8'hC0, 8'h3C, 8'hFF, 8'h00, 8'hAA};
        logic       t_lr   [6] = '{1'b1,  1'b0,  1'b0,  1'b1,  1'b0,  1'b1};
        int         t_cyc  [6] = '{5,     3,     2,     2,     2,     3};
        logic [2:0] t_amt  [6] = '{3'd3,  3'd1,  3'd0,  3'd0,  3'd0,  3'd1};
        logic [7:0] t_mask [6] = '{8'h08, 8'h02, 8'h01, 8'hFF, 8'hFF, 8'hAA};
        int cyc;
        int exp_cyc;
        for (int i = 0; i < 6; i++) begin
            launch(t_ref[i], t_dat[i], t_lr[i], cyc);
            exp_cyc = MASK_MODE ? DATA_W + 1 : t_cyc[i];
            n_cmp++;
            if (cyc !== exp_cyc) begin
                n_err++;
                $display("FAIL vec%0d_latency: got cycle %0d want %0d", i, cyc, exp_cyc);
            end
            n_cmp++;
            if (found !== 1'b1 || amt !== t_amt[i] || recovered !== t_ref[i]) begin
                n_err++;
                $display("FAIL vec%0d_result: got found=%b amt=%0d rec=%h want 1 %0d %h",
                         i, found, amt, recovered, t_amt[i], t_ref[i]);
            end
`ifdef ROT_FIND_MASK_EN
            n_cmp++;
            if (match_mask !== t_mask[i]) begin
                n_err++;
                $display("FAIL vec%0d_mask: got %h want %h", i, match_mask, t_mask[i]);
            end
`else
            if (t_mask[i] == 8'h00) $display("note: vector %0d has empty mask", i);
`endif
            @(negedge clk);
            n_cmp++;
            if (done !== 1'b0 || busy !== 1'b0 || amt !== t_amt[i]) begin
                n_err++;
                $display("FAIL vec%0d_after_done: got done=%b busy=%b amt=%0d want 0 0 %0d",
                         i, done, busy, amt, t_amt[i]);
            end
        end
    endtask

    task automatic test_miss_ignore_start();
        int cyc;
        int extra;
        @(negedge clk);
        ref_in = 8'h0F; data_in = 8'h1F; lr = 1'b1; start = 1'b1;
        @(negedge clk);
        cyc = 1;
        while (done !== 1'b1 && cyc < 40) begin
            n_cmp++;
            if (busy !== 1'b1) begin
                n_err++;
                $display("FAIL miss_busy: got %b want 1 in cycle %0d", busy, cyc);
            end
            start = cyc[0];
            data_in = 8'h0F;
            @(negedge clk);
            cyc++;
        end
        start = 1'b0;
        n_cmp++;
        if (cyc !== DATA_W + 1) begin
            n_err++;
            $display("FAIL miss_latency: got cycle %0d want %0d", cyc, DATA_W + 1);
        end
        n_cmp++;
        if (found !== 1'b0 || amt !== 3'd0 || recovered !== 8'h1F) begin
            n_err++;
            $display("FAIL miss_result: got found=%b amt=%0d rec=%h want 0 0 1f",
                     found, amt, recovered);
        end
`ifdef ROT_FIND_MASK_EN
        n_cmp++;
        if (match_mask !== 8'h00) begin
            n_err++;
            $display("FAIL miss_mask: got %h want 00", match_mask);
        end
`endif
        extra = 0;
        for (int k = 0; k < 15; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) extra++;
        end
        n_cmp++;
        if (extra !== 0) begin
            n_err++;
            $display("FAIL miss_no_queue: got %0d active cycles want 0", extra);
        end
    endtask

    task automatic test_reset_mid();
        int active;
        @(negedge clk);
        ref_in = 8'h0F; data_in = 8'h1F; lr = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        n_cmp++;
        if ({busy, done, found, amt, recovered} !== 13'd0) begin
            n_err++;
            $display("FAIL reset_mid: got busy=%b done=%b found=%b amt=%0d rec=%h want all 0",
                     busy, done, found, amt, recovered);
        end
`ifdef ROT_FIND_MASK_EN
        n_cmp++;
        if (match_mask !== 8'h00) begin
            n_err++;
            $display("FAIL reset_mid_mask: got %h want 00", match_mask);
        end
`endif
        active = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) active++;
        end
        n_cmp++;
        if (active !== 0) begin
            n_err++;
            $display("FAIL reset_mid_no_done: got %0d active cycles want 0", active);
        end
    endtask

    initial begin
        test_reset();
        test_miss_ignore_start();
        test_vectors();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
